// File: rtl/control_unit.sv
// Multi-cycle accumulator-machine control unit: fetch/decode/execute/memory
// sequencing, program counter, instruction register and executed-clock counter.
module control_unit #(
  parameter int unsigned N_BUS  = 16,
  parameter int unsigned N_ADDR = 11,
  parameter int unsigned N_OPC  = 5,
  parameter int unsigned N_CNT  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_run,
  input  logic [N_BUS-1:0]  i_instr,
  output logic [N_ADDR-1:0] o_pc,
  output logic              o_rd_prog,
  output logic [N_ADDR-1:0] o_operand,
  output logic [1:0]        o_SelA,
  output logic              o_SelB,
  output logic              o_Op,
  output logic              o_WrAcc,
  output logic              o_WrRam,
  output logic              o_RdRam,
  output logic              o_halt,
  output logic [N_CNT-1:0]  o_cycles
);

  localparam logic [N_OPC-1:0] OP_HLT  = N_OPC'(0);
  localparam logic [N_OPC-1:0] OP_STO  = N_OPC'(1);
  localparam logic [N_OPC-1:0] OP_LD   = N_OPC'(2);
  localparam logic [N_OPC-1:0] OP_LDI  = N_OPC'(3);
  localparam logic [N_OPC-1:0] OP_ADD  = N_OPC'(4);
  localparam logic [N_OPC-1:0] OP_ADDI = N_OPC'(5);
  localparam logic [N_OPC-1:0] OP_SUB  = N_OPC'(6);
  localparam logic [N_OPC-1:0] OP_SUBI = N_OPC'(7);

  localparam logic [1:0] SEL_A_MEM = 2'd0;
  localparam logic [1:0] SEL_A_IMM = 2'd1;
  localparam logic [1:0] SEL_A_ALU = 2'd2;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [N_ADDR-1:0]  pc_q, pc_d;
  logic [N_BUS-1:0]   ir_q, ir_d;
  logic [N_CNT-1:0]   cycles_q;
  logic [N_OPC-1:0]   opcode;

  logic               wr_acc_q, wr_acc_d;
  logic               wr_ram_q, wr_ram_d;
  logic               rd_ram_q, rd_ram_d;
  logic [1:0]         sel_a_q, sel_a_d;
  logic               sel_b_q, sel_b_d;
  logic               op_q, op_d;
  logic               halt_q, halt_d;

  assign opcode = ir_q[N_BUS-1 -: N_OPC];

  // Next state, PC/IR updates and the strobe set registered for the following cycle.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    wr_acc_d = 1'b0;
    wr_ram_d = 1'b0;
    rd_ram_d = 1'b0;
    sel_a_d  = SEL_A_MEM;
    sel_b_d  = 1'b0;
    op_d     = 1'b0;

    case (state_q)
      S_FETCH: begin
        if (i_run) begin
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        ir_d    = i_instr;
        state_d = S_EXEC;
      end

      S_EXEC: begin
        case (opcode)
          OP_HLT: begin
            state_d = S_HALT;
          end
          OP_STO: begin
            wr_ram_d = 1'b1;
            pc_d     = pc_q + N_ADDR'(1);
            state_d  = S_FETCH;
          end
          OP_LD, OP_ADD, OP_SUB: begin
            rd_ram_d = 1'b1;
            state_d  = S_MEM;
          end
          OP_LDI: begin
            wr_acc_d = 1'b1;
            sel_a_d  = SEL_A_IMM;
            pc_d     = pc_q + N_ADDR'(1);
            state_d  = S_FETCH;
          end
          OP_ADDI, OP_SUBI: begin
            wr_acc_d = 1'b1;
            sel_a_d  = SEL_A_ALU;
            sel_b_d  = 1'b1;
            op_d     = (opcode == OP_SUBI);
            pc_d     = pc_q + N_ADDR'(1);
            state_d  = S_FETCH;
          end
          default: begin
            pc_d    = pc_q + N_ADDR'(1);
            state_d = S_FETCH;
          end
        endcase
      end

      // Only LD/ADD/SUB reach here; data-memory word is presented next cycle.
      S_MEM: begin
        wr_acc_d = 1'b1;
        if (opcode == OP_LD) begin
          sel_a_d = SEL_A_MEM;
        end else begin
          sel_a_d = SEL_A_ALU;
          sel_b_d = 1'b0;
          op_d    = (opcode == OP_SUB);
        end
        pc_d    = pc_q + N_ADDR'(1);
        state_d = S_FETCH;
      end

      S_HALT: begin
        state_d = S_HALT;
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  assign halt_d = (state_d == S_HALT);

  // State, datapath registers and registered control outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_FETCH;
      pc_q     <= '0;
      ir_q     <= '0;
      wr_acc_q <= 1'b0;
      wr_ram_q <= 1'b0;
      rd_ram_q <= 1'b0;
      sel_a_q  <= SEL_A_MEM;
      sel_b_q  <= 1'b0;
      op_q     <= 1'b0;
      halt_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      wr_acc_q <= wr_acc_d;
      wr_ram_q <= wr_ram_d;
      rd_ram_q <= rd_ram_d;
      sel_a_q  <= sel_a_d;
      sel_b_q  <= sel_b_d;
      op_q     <= op_d;
      halt_q   <= halt_d;
    end
  end

  // Executed-clock counter: frozen in HALT, saturates at all-ones.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cycles_q <= '0;
    end else if ((state_q != S_HALT) && (cycles_q != {N_CNT{1'b1}})) begin
      cycles_q <= cycles_q + N_CNT'(1);
    end
  end

  // The ROM samples its address on the same edge that leaves FETCH, so the
  // read strobe must be valid during FETCH itself.
  assign o_rd_prog = (state_q == S_FETCH) && i_run && !i_rst;

  assign o_pc      = pc_q;
  assign o_operand = ir_q[N_ADDR-1:0];
  assign o_SelA    = sel_a_q;
  assign o_SelB    = sel_b_q;
  assign o_Op      = op_q;
  assign o_WrAcc   = wr_acc_q;
  assign o_WrRam   = wr_ram_q;
  assign o_RdRam   = rd_ram_q;
  assign o_halt    = halt_q;
  assign o_cycles  = cycles_q;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: instruction-level latency model checked
// every cycle, plus directed programs with hand-computed event timings.
module tb_control_unit;

  localparam int unsigned N_BUS  = 16;
  localparam int unsigned N_ADDR = 11;
  localparam int unsigned N_OPC  = 5;
  localparam int unsigned N_CNT  = 16;

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b1;
  logic              i_run = 1'b0;
  logic [N_BUS-1:0]  i_instr = '0;
  logic [N_ADDR-1:0] o_pc;
  logic              o_rd_prog;
  logic [N_ADDR-1:0] o_operand;
  logic [1:0]        o_SelA;
  logic              o_SelB;
  logic              o_Op;
  logic              o_WrAcc;
  logic              o_WrRam;
  logic              o_RdRam;
  logic              o_halt;
  logic [N_CNT-1:0]  o_cycles;

  control_unit #(.N_BUS(N_BUS), .N_ADDR(N_ADDR), .N_OPC(N_OPC), .N_CNT(N_CNT)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_run(i_run), .i_instr(i_instr),
    .o_pc(o_pc), .o_rd_prog(o_rd_prog), .o_operand(o_operand),
    .o_SelA(o_SelA), .o_SelB(o_SelB), .o_Op(o_Op), .o_WrAcc(o_WrAcc),
    .o_WrRam(o_WrRam), .o_RdRam(o_RdRam), .o_halt(o_halt), .o_cycles(o_cycles)
  );

  always #5 i_clk = ~i_clk;

  // Synchronous program ROM
  logic [15:0] rom [0:2047];
  always @(posedge i_clk) if (o_rd_prog) i_instr <= rom[o_pc];

  typedef struct {
    int          c;
    logic [1:0]  sa;
    logic        sb;
    logic        op;
    logic [10:0] opd;
  } ev_t;

  ev_t ev_wa[$];
  ev_t ev_rr[$];
  ev_t ev_wr[$];
  int  first_halt;
  int  n_rd;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int t0    = 0;

  // Instruction-level model: time since fetch (k) of the current instruction
  bit          m_valid = 0;
  bit          m_have  = 0;
  logic [15:0] m_instr = '0;
  int          m_k     = 0;
  logic [10:0] m_pc    = '0;
  logic [10:0] m_operand = '0;
  int          m_cycles = 0;

  function automatic int lat(input logic [4:0] opc);
    return (opc == 5'd2 || opc == 5'd4 || opc == 5'd6) ? 4 : 3;
  endfunction

  function automatic bit is_mem_op(input logic [4:0] opc);
    return (opc == 5'd2 || opc == 5'd4 || opc == 5'd6);
  endfunction

  function automatic bit is_imm_acc(input logic [4:0] opc);
    return (opc == 5'd3 || opc == 5'd5 || opc == 5'd7);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Per-cycle compare against the model, then advance the model by one clock.
  task automatic model_step();
    logic [4:0]  opc;
    bit          free, e_rd, e_wa, e_wr, e_rr, e_halt, e_sb, e_op;
    logic [1:0]  e_sa;
    logic [46:0] exp_v, act_v;
    opc    = m_instr[15:11];
    free   = !m_have || (opc != 5'd0 && m_k >= lat(opc));
    e_halt = m_have && opc == 5'd0 && m_k >= 3;
    e_rd   = free && i_run && !i_rst;
    e_wa   = m_have && ((m_k == 3 && is_imm_acc(opc)) || (m_k == 4 && is_mem_op(opc)));
    e_rr   = m_have && m_k == 3 && is_mem_op(opc);
    e_wr   = m_have && m_k == 3 && opc == 5'd1;
    e_sa   = !e_wa ? 2'd0 : (opc == 5'd3) ? 2'd1 : (opc == 5'd2) ? 2'd0 : 2'd2;
    e_sb   = e_wa && (opc == 5'd5 || opc == 5'd7);
    e_op   = e_wa && (opc == 5'd6 || opc == 5'd7);
    if (m_valid) begin
      exp_v = {e_rd, e_wa, e_wr, e_rr, e_sa, e_sb, e_op, e_halt, m_pc, m_operand, 16'(m_cycles)};
      act_v = {o_rd_prog, o_WrAcc, o_WrRam, o_RdRam, o_SelA, o_SelB, o_Op, o_halt,
               o_pc, o_operand, o_cycles};
      n_cmp++;
      if (act_v !== exp_v) begin
        n_err++;
        $display("FAIL cycle %0d outputs: got %h expected %h", cyc, act_v, exp_v);
      end
    end
    if (i_rst) begin
      m_valid = 1; m_have = 0; m_k = 0; m_pc = '0; m_operand = '0; m_cycles = 0; m_instr = '0;
    end else if (m_valid) begin
      if (!e_halt && m_cycles < 65535) m_cycles++;
      if (e_rd) begin
        m_have = 1; m_instr = rom[m_pc]; m_k = 1;
      end else if (m_have && m_k < 1000) begin
        m_k++;
      end
      opc = m_instr[15:11];
      if (m_have && m_k == 2) m_operand = m_instr[10:0];
      if (m_have && m_k == lat(opc) && opc != 5'd0) m_pc = m_pc + 11'd1;
    end
  endtask

  // One clock: check at the falling edge, return 1 time unit after the rising edge.
  task automatic tick();
    ev_t e;
    @(negedge i_clk);
    model_step();
    e.c = cyc - t0; e.sa = o_SelA; e.sb = o_SelB; e.op = o_Op; e.opd = o_operand;
    if (o_WrAcc) ev_wa.push_back(e);
    if (o_RdRam) ev_rr.push_back(e);
    if (o_WrRam) ev_wr.push_back(e);
    if (o_rd_prog) n_rd++;
    if (o_halt && first_halt < 0) first_halt = cyc - t0;
    @(posedge i_clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input bit run);
    i_rst = 1'b1;
    i_run = run;
    tick();
    i_rst = 1'b0;
    t0 = cyc;
    ev_wa.delete(); ev_rr.delete(); ev_wr.delete();
    first_halt = -1;
    n_rd = 0;
  endtask

  task automatic fill_rom(input logic [15:0] w);
    for (int i = 0; i < 2048; i++) rom[i] = w;
  endtask

  initial begin
    int c0, n;
    logic [4:0] opc;
    fill_rom(16'h4000);
    @(posedge i_clk);
    #1;

    // Reset state
    do_reset(1'b0);
    chk("reset_pc", int'(o_pc), 0);
    chk("reset_cycles", int'(o_cycles), 0);
    chk("reset_halt", int'(o_halt), 0);

    // LDI 5, ADDI 3, HLT
    rom[0] = 16'h1805; rom[1] = 16'h2803; rom[2] = 16'h0000;
    do_reset(1'b1);
    repeat (14) tick();
    chk("p1_wacc_n", ev_wa.size(), 2);
    if (ev_wa.size() == 2) begin
      chk("p1_wacc0_cyc", ev_wa[0].c, 3);
      chk("p1_wacc0_sela", int'(ev_wa[0].sa), 1);
      chk("p1_wacc1_cyc", ev_wa[1].c, 6);
      chk("p1_wacc1_sela", int'(ev_wa[1].sa), 2);
      chk("p1_wacc1_selb", int'(ev_wa[1].sb), 1);
      chk("p1_wacc1_op", int'(ev_wa[1].op), 0);
    end
    chk("p1_halt_cyc", first_halt, 9);
    chk("p1_pc", int'(o_pc), 2);

    // LD 0x010, SUB 0x011, STO 0x012, HLT
    fill_rom(16'h4000);
    rom[0] = 16'h1010; rom[1] = 16'h3011; rom[2] = 16'h0812; rom[3] = 16'h0000;
    do_reset(1'b1);
    repeat (18) tick();
    chk("p2_rd_n", ev_rr.size(), 2);
    chk("p2_wacc_n", ev_wa.size(), 2);
    chk("p2_wr_n", ev_wr.size(), 1);
    if (ev_rr.size() == 2 && ev_wa.size() == 2 && ev_wr.size() == 1) begin
      chk("p2_ld_rd_cyc", ev_rr[0].c, 3);
      chk("p2_ld_rd_opd", int'(ev_rr[0].opd), 'h010);
      chk("p2_ld_wacc_cyc", ev_wa[0].c, 4);
      chk("p2_ld_sela", int'(ev_wa[0].sa), 0);
      chk("p2_sub_rd_cyc", ev_rr[1].c, 7);
      chk("p2_sub_wacc_cyc", ev_wa[1].c, 8);
      chk("p2_sub_op", int'(ev_wa[1].op), 1);
      chk("p2_sub_selb", int'(ev_wa[1].sb), 0);
      chk("p2_sub_sela", int'(ev_wa[1].sa), 2);
      chk("p2_sto_cyc", ev_wr[0].c, 11);
      chk("p2_sto_opd", int'(ev_wr[0].opd), 'h012);
    end
    chk("p2_halt_cyc", first_halt, 14);

    // Stall in FETCH with i_run=0
    do_reset(1'b0);
    c0 = int'(o_cycles);
    repeat (10) tick();
    chk("stall_rdprog", n_rd, 0);
    chk("stall_pc", int'(o_pc), 0);
    chk("stall_cycles", int'(o_cycles) - c0, 10);

    // Reset during MEM of LD
    rom[0] = 16'h1005;
    do_reset(1'b1);
    repeat (3) tick();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    chk("rstmem_wacc", int'(o_WrAcc), 0);
    chk("rstmem_pc", int'(o_pc), 0);
    chk("rstmem_cycles", int'(o_cycles), 0);

    // Opcode 11111 then HLT, then i_run toggling while halted
    rom[0] = 16'hF800; rom[1] = 16'h0000;
    do_reset(1'b1);
    repeat (3) tick();
    chk("nop31_pc", int'(o_pc), 1);
    chk("nop31_strobes", ev_wa.size() + ev_rr.size() + ev_wr.size(), 0);
    repeat (4) tick();
    c0 = int'(o_cycles);
    for (int i = 0; i < 20; i++) begin
      i_run = 1'($urandom_range(0, 1));
      tick();
    end
    chk("halt_stays", int'(o_halt), 1);
    chk("halt_cycles_frozen", int'(o_cycles), c0);
    chk("halt_pc", int'(o_pc), 1);

    // PC wrap from 2047 to 0 on NOP
    fill_rom(16'h4000);
    do_reset(1'b1);
    n = 0;
    while (o_pc != 11'd2047 && n < 7000) begin tick(); n++; end
    chk("wrap_reached", int'(o_pc), 2047);
    n = 0;
    while (o_pc == 11'd2047 && n < 10) begin tick(); n++; end
    chk("wrap_pc", int'(o_pc), 0);
    chk("wrap_latency", n, 3);

    // Randomized programs and run/reset activity
    for (int seg = 0; seg < 6; seg++) begin
      for (int i = 0; i < 2048; i++) begin
        opc = 5'($urandom_range(0, 31));
        if (opc == 5'd0 && $urandom_range(0, 7) != 0) opc = 5'd8;
        rom[i] = {opc, 11'($urandom)};
      end
      do_reset(1'($urandom_range(0, 1)));
      for (int i = 0; i < 500; i++) begin
        i_run = ($urandom_range(0, 99) < 75);
        i_rst = ($urandom_range(0, 99) < 2);
        tick();
      end
      i_rst = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
